// File: rtl/fifo_flush_multi_if.sv
// Handshake/bus bundle for fifo_flush_multi.
//   master : producer/consumer side (drives write, flush, ready; observes beat and status)
//   slave  : the FIFO itself
`timescale 1ns/1ps
interface fifo_flush_multi_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned PACK   = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic                   fifo_wr_valid_i;
  logic [DATA_W-1:0]      fifo_wr_data_i;
  logic                   fifo_flush_i;
  logic                   fifo_rd_ready_i;
  logic                   fifo_rd_valid_o;
  logic [DATA_W*PACK-1:0] fifo_rd_data_o;
  logic                   fifo_rd_last_o;
  logic                   fifo_flush_done_o;
  logic [LW-1:0]          fifo_level_o;
  logic                   fifo_empty_o;
  logic                   fifo_full_o;
  logic                   fifo_data_avail_o;
  logic [7:0]             fifo_ovf_cnt_o;

  modport master (
    output fifo_wr_valid_i, fifo_wr_data_i, fifo_flush_i, fifo_rd_ready_i,
    input  fifo_rd_valid_o, fifo_rd_data_o, fifo_rd_last_o, fifo_flush_done_o,
           fifo_level_o, fifo_empty_o, fifo_full_o, fifo_data_avail_o, fifo_ovf_cnt_o
  );

  modport slave (
    input  fifo_wr_valid_i, fifo_wr_data_i, fifo_flush_i, fifo_rd_ready_i,
    output fifo_rd_valid_o, fifo_rd_data_o, fifo_rd_last_o, fifo_flush_done_o,
           fifo_level_o, fifo_empty_o, fifo_full_o, fifo_data_avail_o, fifo_ovf_cnt_o
  );
endinterface

// File: rtl/fifo_flush_multi.sv
// FIFO that is drained on request in packed multi-entry beats.
//   clk   : single clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : fifo_flush_multi_if.slave (write port, flush request, packed read beat,
//           level/empty/full/data_avail status, dropped-write count)
// Optional feature: define FIFO_FLUSH_MULTI_OVF_CNT_EN to build the saturating
// dropped-write counter; otherwise fifo_ovf_cnt_o is tied to 0.
`timescale 1ns/1ps
module fifo_flush_multi #(
  parameter int unsigned       DATA_W       = 4,
  parameter int unsigned       DEPTH        = 32,
  parameter int unsigned       PACK         = 8,
  parameter int unsigned       AVAIL_THRESH = 4,
  parameter logic [DATA_W-1:0] PAD          = DATA_W'('hC)
) (
  input logic                clk,
  input logic                reset,
  fifo_flush_multi_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned OW = DATA_W * PACK;

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     count, remaining;
  logic [LW-1:0]     n_c;
  logic              full_c, last_c, wr_acc_c, pop_c;
  logic [OW-1:0]     rd_data_c;

  // Status decoded straight from the occupancy count
  assign full_c                = (count == LW'(DEPTH));
  assign bus.fifo_full_o       = full_c;
  assign bus.fifo_empty_o      = (count == '0);
  assign bus.fifo_data_avail_o = (32'(count) >= AVAIL_THRESH);
  assign bus.fifo_level_o      = count;

  // Entries in the current beat and whether it finishes the snapshot
  assign n_c      = (remaining < LW'(PACK)) ? remaining : LW'(PACK);
  assign last_c   = (remaining <= LW'(PACK));
  assign wr_acc_c = bus.fifo_wr_valid_i && !full_c;
  assign pop_c    = (state == FLUSH) && bus.fifo_rd_ready_i;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; flush requests outside IDLE are ignored
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.fifo_flush_i) state_nx = (count != '0) ? FLUSH : DONE;
      FLUSH:   if (pop_c && last_c)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic; beat lanes beyond the valid entries carry PAD, idle bus is zero
  always_comb begin
    bus.fifo_rd_valid_o   = 1'b0;
    bus.fifo_rd_last_o    = 1'b0;
    bus.fifo_flush_done_o = 1'b0;
    rd_data_c             = '0;
    if (state == FLUSH) begin
      bus.fifo_rd_valid_o = 1'b1;
      bus.fifo_rd_last_o  = last_c;
      for (int i = 0; i < int'(PACK); i++) begin
        if (LW'(i) < n_c) rd_data_c[i*DATA_W +: DATA_W] = mem[rd_ptr + AW'(i)];
        else              rd_data_c[i*DATA_W +: DATA_W] = PAD;
      end
    end
    if (state == DONE) bus.fifo_flush_done_o = 1'b1;
  end

  assign bus.fifo_rd_data_o = rd_data_c;

  // Storage array; contents are don't-care while not counted
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem[wr_ptr] <= bus.fifo_wr_data_i;
  end

  // Pointers, count and flush snapshot; writes after the snapshot stay queued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)    rd_ptr <= rd_ptr + AW'(n_c);
      count <= count + LW'(wr_acc_c) - (pop_c ? n_c : LW'(0));
      if (state == IDLE && bus.fifo_flush_i) remaining <= count;
      else if (pop_c)                        remaining <= remaining - n_c;
    end
  end

`ifdef FIFO_FLUSH_MULTI_OVF_CNT_EN
  logic [7:0] ovf_cnt;
  logic       wr_drop_c;

  assign wr_drop_c = bus.fifo_wr_valid_i && full_c;

  // Saturating count of writes dropped while full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           ovf_cnt <= 8'd0;
    else if (wr_drop_c && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end

  assign bus.fifo_ovf_cnt_o = ovf_cnt;
`else
  assign bus.fifo_ovf_cnt_o = 8'd0;
`endif
endmodule

// File: tb/tb_fifo_flush_multi.sv
// Self-checking bench for fifo_flush_multi (default parameters).
// A queue-based model predicts every output each cycle; directed scenarios add
// hand-computed literal expectations. Honours FIFO_FLUSH_MULTI_OVF_CNT_EN.
`timescale 1ns/1ps
module tb_fifo_flush_multi;
  localparam int unsigned DW = 4;
  localparam int unsigned DP = 32;
  localparam int unsigned PK = 8;
  localparam logic [3:0]  PADV = 4'hC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fifo_flush_multi_if #(.DATA_W(DW), .DEPTH(DP), .PACK(PK)) bus ();

  fifo_flush_multi dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: queue of stored entries plus flush progress
  logic [3:0] mq[$];
  bit         m_fl   = 1'b0;
  bit         m_done = 1'b0;
  int         m_rem  = 0;
  int         m_ovf  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_fl = 1'b0; m_done = 1'b0; m_rem = 0; m_ovf = 0;
    end else begin
      int sz, n, rem_n;
      bit fl_n, done_n;
      sz = mq.size(); fl_n = m_fl; done_n = 1'b0; rem_n = m_rem;
      if (m_fl) begin
        if (bus.fifo_rd_ready_i) begin
          n = (m_rem < PK) ? m_rem : PK;
          repeat (n) void'(mq.pop_front());
          rem_n = m_rem - n;
          if (rem_n == 0) begin fl_n = 1'b0; done_n = 1'b1; end
        end
      end else if (!m_done && bus.fifo_flush_i) begin
        rem_n = sz;
        if (sz > 0) fl_n = 1'b1; else done_n = 1'b1;
      end
      if (bus.fifo_wr_valid_i) begin
        if (sz < DP) mq.push_back(bus.fifo_wr_data_i);
        else if (m_ovf < 255) m_ovf++;
      end
      m_fl = fl_n; m_done = done_n; m_rem = rem_n;
    end
  end

  function automatic int exp_ovf();
`ifdef FIFO_FLUSH_MULTI_OVF_CNT_EN
    return m_ovf;
`else
    return 0;
`endif
  endfunction

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [31:0] ed;
    int n;
    ed = '0;
    n = (m_rem < PK) ? m_rem : PK;
    if (m_fl)
      for (int i = 0; i < int'(PK); i++) ed[i*4 +: 4] = (i < n) ? mq[i] : PADV;
    check("m_rd_valid", 64'(bus.fifo_rd_valid_o), 64'(m_fl));
    check("m_rd_data",  64'(bus.fifo_rd_data_o), 64'(ed));
    check("m_rd_last",  64'(bus.fifo_rd_last_o), 64'(m_fl && m_rem <= PK));
    check("m_done",     64'(bus.fifo_flush_done_o), 64'(m_done));
    check("m_level",    64'(bus.fifo_level_o), 64'(mq.size()));
    check("m_flags",    64'({bus.fifo_empty_o, bus.fifo_full_o, bus.fifo_data_avail_o}),
          64'({mq.size() == 0, mq.size() == DP, mq.size() >= 4}));
    check("m_ovf",      64'(bus.fifo_ovf_cnt_o), 64'(exp_ovf()));
  end

  task automatic wr(input logic [3:0] d);
    bus.fifo_wr_valid_i = 1'b1;
    bus.fifo_wr_data_i  = d;
    step();
    bus.fifo_wr_valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] eb;
    int writes, beats;
    bit seen;
    bus.fifo_wr_valid_i = 1'b0;
    bus.fifo_wr_data_i  = '0;
    bus.fifo_flush_i    = 1'b0;
    bus.fifo_rd_ready_i = 1'b0;

    // Reset values, in and after reset
    step(); step();
    check("rst_out", 64'({bus.fifo_empty_o, bus.fifo_full_o, bus.fifo_data_avail_o,
                          bus.fifo_rd_valid_o, bus.fifo_rd_last_o, bus.fifo_flush_done_o}),
          64'(6'b100000));
    rst_n = 1'b1;
    step();
    check("rst_level", 64'(bus.fifo_level_o), 64'd0);
    check("rst_data",  64'(bus.fifo_rd_data_o), 64'd0);
    check("rst_ovf",   64'(bus.fifo_ovf_cnt_o), 64'd0);

    // Three writes, single short beat
    wr(4'h1); wr(4'h2); wr(4'h3);
    bus.fifo_flush_i = 1'b1; bus.fifo_rd_ready_i = 1'b1;
    step();
    bus.fifo_flush_i = 1'b0;
    check("b3_data", 64'(bus.fifo_rd_data_o), 64'h0000_0000_CCCC_C321);
    check("b3_last", 64'({bus.fifo_rd_valid_o, bus.fifo_rd_last_o}), 64'd3);
    step();
    check("b3_done",  64'(bus.fifo_flush_done_o), 64'd1);
    check("b3_empty", 64'(bus.fifo_empty_o), 64'd1);
    step();
    check("b3_done_clr", 64'(bus.fifo_flush_done_o), 64'd0);

    // Twenty entries, back-pressure on the first beat
    for (int i = 0; i < 20; i++) wr(4'(i));
    bus.fifo_rd_ready_i = 1'b0; bus.fifo_flush_i = 1'b1;
    step();
    bus.fifo_flush_i = 1'b0;
    check("b20_first", 64'(bus.fifo_rd_data_o), 64'h7654_3210);
    step(); step();
    check("b20_hold", 64'(bus.fifo_rd_data_o), 64'h7654_3210);
    check("b20_hold_last", 64'(bus.fifo_rd_last_o), 64'd0);
    bus.fifo_rd_ready_i = 1'b1;
    step();
    check("b20_second", 64'(bus.fifo_rd_data_o), 64'hFEDC_BA98);
    check("b20_second_last", 64'(bus.fifo_rd_last_o), 64'd0);
    step();
    check("b20_third", 64'(bus.fifo_rd_data_o), 64'hCCCC_3210);
    check("b20_third_last", 64'(bus.fifo_rd_last_o), 64'd1);
    step();
    check("b20_done", 64'(bus.fifo_flush_done_o), 64'd1);
    step();

    // Overfill to 33 writes, then drain four full beats across the wrap
    for (int i = 0; i < 33; i++) wr(4'(i));
    check("full_flag", 64'(bus.fifo_full_o), 64'd1);
    check("full_level", 64'(bus.fifo_level_o), 64'd32);
`ifdef FIFO_FLUSH_MULTI_OVF_CNT_EN
    check("full_ovf", 64'(bus.fifo_ovf_cnt_o), 64'd1);
`else
    check("full_ovf", 64'(bus.fifo_ovf_cnt_o), 64'd0);
`endif
    bus.fifo_rd_ready_i = 1'b1; bus.fifo_flush_i = 1'b1;
    step();
    bus.fifo_flush_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      eb = (b % 2 == 1) ? 32'hFEDC_BA98 : 32'h7654_3210;
      check("b32_data", 64'(bus.fifo_rd_data_o), 64'(eb));
      check("b32_last", 64'(bus.fifo_rd_last_o), 64'(b == 3));
      step();
    end
    check("b32_done", 64'(bus.fifo_flush_done_o), 64'd1);
    check("b32_empty", 64'(bus.fifo_empty_o), 64'd1);
    step();
    for (int i = 0; i < 5; i++) wr(4'(4'hA + i));
    bus.fifo_flush_i = 1'b1;
    step();
    bus.fifo_flush_i = 1'b0;
    check("wrap_data", 64'(bus.fifo_rd_data_o), 64'hCCCE_DCBA);
    check("wrap_last", 64'(bus.fifo_rd_last_o), 64'd1);
    step();
    step();

    // Flush on an empty FIFO
    bus.fifo_flush_i = 1'b1;
    step();
    bus.fifo_flush_i = 1'b0;
    check("empty_valid", 64'(bus.fifo_rd_valid_o), 64'd0);
    check("empty_done", 64'(bus.fifo_flush_done_o), 64'd1);
    step();
    check("empty_done_clr", 64'(bus.fifo_flush_done_o), 64'd0);

    // Ten entries flushed while writing every cycle; flush held into FLUSH is ignored
    for (int i = 0; i < 10; i++) wr(4'(i));
    bus.fifo_flush_i = 1'b1; bus.fifo_rd_ready_i = 1'b1; bus.fifo_wr_valid_i = 1'b1;
    writes = 0; beats = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.fifo_rd_valid_o && bus.fifo_rd_ready_i) beats++;
      bus.fifo_wr_data_i = 4'(k + 5);
      step();
      writes++;
      if (k >= 1) bus.fifo_flush_i = 1'b0;
      seen = bus.fifo_flush_done_o;
    end
    bus.fifo_wr_valid_i = 1'b0; bus.fifo_flush_i = 1'b0;
    check("wf_done_seen", 64'(seen), 64'd1);
    check("wf_beats", 64'(beats), 64'd2);
    check("wf_level", 64'(bus.fifo_level_o), 64'(writes));
    check("wf_level_lit", 64'(bus.fifo_level_o), 64'd3);
    check("wf_avail", 64'(bus.fifo_data_avail_o), 64'd0);
    step();

    // Reset asserted mid-flush aborts without a done pulse
    bus.fifo_rd_ready_i = 1'b0; bus.fifo_flush_i = 1'b1;
    step();
    bus.fifo_flush_i = 1'b0;
    check("abort_valid_pre", 64'(bus.fifo_rd_valid_o), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(bus.fifo_rd_valid_o), 64'd0);
    check("abort_level", 64'(bus.fifo_level_o), 64'd0);
    check("abort_done",  64'(bus.fifo_flush_done_o), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("abort_done_after", 64'(bus.fifo_flush_done_o), 64'd0);
    check("abort_empty", 64'(bus.fifo_empty_o), 64'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_flush_multi.md
FIFO_FLUSH_MULTI -- requirements
Module: fifo_flush_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 4, entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, entry count, power of two, at least 2.
REQ-003 SHALL have parameter PACK, default 8, entries per output beat, at least 1 and at most DEPTH.
REQ-004 SHALL have parameter AVAIL_THRESH, default 4, level at or above which data_avail asserts.
REQ-005 SHALL have parameter PAD, default 'hC (DATA_W bits), fill value for unused output lanes.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-008 SHALL have port fifo_wr_valid_i, input, 1, write strobe.
REQ-009 SHALL have port fifo_wr_data_i, input, DATA_W, write entry.
REQ-010 SHALL have port fifo_flush_i, input, 1, drain request.
REQ-011 SHALL have port fifo_rd_ready_i, input, 1, consumer accepts the current beat.
REQ-012 SHALL have port fifo_rd_valid_o, output, 1, beat valid.
REQ-013 SHALL have port fifo_rd_data_o, output, DATA_W*PACK, packed beat; lane 0 (LSBs) is the oldest entry.
REQ-014 SHALL have port fifo_rd_last_o, output, 1, final beat of the flush.
REQ-015 SHALL have port fifo_flush_done_o, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port fifo_level_o, output, $clog2(DEPTH)+1, occupancy.
REQ-017 SHALL have ports fifo_empty_o, fifo_full_o and fifo_data_avail_o, each output, 1.
REQ-018 SHALL have port fifo_ovf_cnt_o, output, 8, dropped-write count.

Function
REQ-019 SHALL keep wr_ptr and rd_ptr at $clog2(DEPTH) bits, wrapping modulo DEPTH, and keep a separate count register.
REQ-020 SHALL define empty as count==0, full as count==DEPTH, and data_avail as count>=AVAIL_THRESH, each decoded combinationally from count.
REQ-021 SHALL store a write when wr_valid=1 and full=0; a write while full is dropped, and the pointers and count are unchanged.
REQ-022 SHALL apply a write and a beat pop in the same cycle; count changes by +1-n.
REQ-023 SHALL implement the FSM states IDLE, FLUSH and DONE.
REQ-024 IDLE: flush_i=1 snapshots remaining=count; if count>0 go to FLUSH, else go to DONE.
REQ-025 FLUSH: rd_valid=1; n=min(PACK,remaining); lanes 0..n-1 = entries rd_ptr..rd_ptr+n-1 (wrapping); lanes n..PACK-1 = PAD.
REQ-026 FLUSH: rd_last=1 when remaining<=PACK.
REQ-027 FLUSH: on valid&ready, rd_ptr+=n, count-=n and remaining-=n; if rd_last, go to DONE.
REQ-028 SHALL hold rd_data stable while valid=1 and ready=0.
REQ-029 DONE: flush_done_o=1 for exactly one cycle, then go to IDLE.
REQ-030 SHALL exclude writes accepted after the snapshot from the current flush; they remain queued.
REQ-031 SHALL ignore flush_i outside IDLE.
REQ-032 SHALL drive rd_data=0 and rd_last=0 when rd_valid=0.
REQ-033 Latency: flush_i sampled in IDLE at edge N gives rd_valid (or flush_done for empty) after edge N.

Reset
REQ-034 SHALL, on reset=0, immediately clear the pointers, count, remaining and ovf count, and force state to IDLE.
REQ-035 Reset values: empty=1, full=0, level=0, avail=0, rd_valid=0, rd_data=0, rd_last=0, done=0, ovf_cnt=0.
REQ-036 Reset asserted mid-flush SHALL abort the flush with no done pulse; storage contents need not be cleared.

Configuration
REQ-037 Macro FIFO_FLUSH_MULTI_OVF_CNT_EN defined: each dropped write increments fifo_ovf_cnt_o, saturating at 255.
REQ-038 Macro FIFO_FLUSH_MULTI_OVF_CNT_EN undefined: no counter logic is built and fifo_ovf_cnt_o is tied to 0.

Verification (defaults)
REQ-039 Release reset -> all outputs at REQ-035 values; assert reset mid-flush -> rd_valid=0 asynchronously and no done pulse.
REQ-040 Write 1,2,3, then flush with ready=1 -> one beat 0xCCCCC321 with last=1, done pulse next cycle, empty=1.
REQ-041 Write 20 entries 0..F,0..3, flush with ready=0 for 2 cycles -> beat held at 0x76543210, then 0xFEDCBA98, then 0xCCCC3210 with last=1.
REQ-042 Write 33 entries -> full=1, level=32, ovf_cnt=1 (0 with the macro undefined); flush -> 4 beats; write 5 more -> wrapped data read back correctly.
REQ-043 Flush on empty -> rd_valid stays 0, done pulse one cycle later, state back in IDLE.
REQ-044 Write every cycle during a flush of 10 entries -> exactly 2 beats, level afterwards equals the writes made during the flush, avail tracks threshold 4.
